// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, response and ALU-side signals for alu_share_arbiter.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             reqa_valid_i;
    logic             reqa_ready_o;
    logic [WIDTH-1:0] reqa_src1_i;
    logic [WIDTH-1:0] reqa_src2_i;
    logic [3:0]       reqa_ctrl_i;

    logic             reqb_valid_i;
    logic             reqb_ready_o;
    logic [WIDTH-1:0] reqb_src1_i;
    logic [WIDTH-1:0] reqb_src2_i;
    logic [3:0]       reqb_ctrl_i;

    logic             rspa_valid_o;
    logic             rspa_ready_i;
    logic [WIDTH-1:0] rspa_result_o;
    logic             rspa_zero_o;

    logic             rspb_valid_o;
    logic             rspb_ready_i;
    logic [WIDTH-1:0] rspb_result_o;
    logic             rspb_zero_o;

    logic [WIDTH-1:0] alu_src1_o;
    logic [WIDTH-1:0] alu_src2_o;
    logic [3:0]       alu_ctrl_o;
    logic [WIDTH-1:0] alu_result_i;
    logic             alu_zero_i;

    logic             busy_o;

    modport slave (
        input  reqa_valid_i, reqa_src1_i, reqa_src2_i, reqa_ctrl_i,
        output reqa_ready_o,
        input  reqb_valid_i, reqb_src1_i, reqb_src2_i, reqb_ctrl_i,
        output reqb_ready_o,
        output rspa_valid_o, rspa_result_o, rspa_zero_o,
        input  rspa_ready_i,
        output rspb_valid_o, rspb_result_o, rspb_zero_o,
        input  rspb_ready_i,
        output alu_src1_o, alu_src2_o, alu_ctrl_o,
        input  alu_result_i, alu_zero_i,
        output busy_o
    );

    modport master (
        output reqa_valid_i, reqa_src1_i, reqa_src2_i, reqa_ctrl_i,
        input  reqa_ready_o,
        output reqb_valid_i, reqb_src1_i, reqb_src2_i, reqb_ctrl_i,
        input  reqb_ready_o,
        input  rspa_valid_o, rspa_result_o, rspa_zero_o,
        output rspa_ready_i,
        input  rspb_valid_o, rspb_result_o, rspb_zero_o,
        output rspb_ready_i,
        input  alu_src1_o, alu_src2_o, alu_ctrl_o,
        output alu_result_i, alu_zero_i,
        input  busy_o
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between requesters A and B, one operation in
// flight, with a held response register per requester and a multicycle multiply.
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input logic clk_i,
    input logic rst_i,
    alu_share_arbiter_if.slave bus
);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q, state_d;
    logic             rrb_q, rrb_d;
    logic             owner_q, owner_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] src1_q, src1_d, src2_q, src2_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] rspa_result_q, rspa_result_d, rspb_result_q, rspb_result_d;
    logic             rspa_zero_q, rspa_zero_d, rspb_zero_q, rspb_zero_d;

    logic             grant_a, grant_b, accept_ok;
    logic [WIDTH-1:0] sel_src1, sel_src2;
    logic [3:0]       sel_ctrl;

    // rrb_q set means B wins the next tie; grant is the arbitration result in IDLE
    assign grant_a   = bus.reqa_valid_i && (!bus.reqb_valid_i || !rrb_q);
    assign grant_b   = bus.reqb_valid_i && (!bus.reqa_valid_i || rrb_q);
    assign sel_src1  = grant_b ? bus.reqb_src1_i : bus.reqa_src1_i;
    assign sel_src2  = grant_b ? bus.reqb_src2_i : bus.reqa_src2_i;
    assign sel_ctrl  = grant_b ? bus.reqb_ctrl_i : bus.reqa_ctrl_i;
    assign accept_ok = (state_q == IDLE) && !rst_i;

    always_comb begin
        state_d       = state_q;
        rrb_d         = rrb_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        ctrl_d        = ctrl_q;
        rspa_result_d = rspa_result_q;
        rspa_zero_d   = rspa_zero_q;
        rspb_result_d = rspb_result_q;
        rspb_zero_d   = rspb_zero_q;
        unique case (state_q)
            IDLE: begin
                if (grant_a || grant_b) begin
                    owner_d = grant_b;
                    rrb_d   = !grant_b;
                    src1_d  = sel_src1;
                    src2_d  = sel_src2;
                    ctrl_d  = sel_ctrl;
                    cnt_d   = (sel_ctrl == 4'd3) ? CW'(MUL_LAT - 1) : '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    if (owner_q) begin
                        rspb_result_d = bus.alu_result_i;
                        rspb_zero_d   = bus.alu_zero_i;
                    end else begin
                        rspa_result_d = bus.alu_result_i;
                        rspa_zero_d   = bus.alu_zero_i;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_q ? bus.rspb_ready_i : bus.rspa_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rrb_q         <= 1'b0;
            owner_q       <= 1'b0;
            cnt_q         <= '0;
            src1_q        <= '0;
            src2_q        <= '0;
            ctrl_q        <= '0;
            rspa_result_q <= '0;
            rspa_zero_q   <= 1'b0;
            rspb_result_q <= '0;
            rspb_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rrb_q         <= rrb_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            ctrl_q        <= ctrl_d;
            rspa_result_q <= rspa_result_d;
            rspa_zero_q   <= rspa_zero_d;
            rspb_result_q <= rspb_result_d;
            rspb_zero_q   <= rspb_zero_d;
        end
    end

    // Ready is gated by reset so the handshake outputs drop the moment reset asserts
    assign bus.reqa_ready_o  = accept_ok && grant_a;
    assign bus.reqb_ready_o  = accept_ok && grant_b;
    assign bus.alu_src1_o    = (state_q == EXEC) ? src1_q : '0;
    assign bus.alu_src2_o    = (state_q == EXEC) ? src2_q : '0;
    assign bus.alu_ctrl_o    = (state_q == EXEC) ? ctrl_q : 4'd0;
    assign bus.rspa_valid_o  = (state_q == RESP) && !owner_q;
    assign bus.rspb_valid_o  = (state_q == RESP) && owner_q;
    assign bus.rspa_result_o = rspa_result_q;
    assign bus.rspa_zero_o   = rspa_zero_q;
    assign bus.rspb_result_o = rspb_result_q;
    assign bus.rspb_zero_o   = rspb_zero_q;
    assign bus.busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a behavioural ALU closes the loop and a
// scoreboard monitor checks every response against hand-computed values.
module tb_alu_share_arbiter;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 3;

    typedef struct {
        logic        isB;
        logic [31:0] result;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   vecCount = 0;
    int   missCount = 0;
    exp_t expQ[$];

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(WIDTH)) bus();

    alu_share_arbiter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Reference ALU: 0 and, 1 or, 2 add, 3 mul, 6 sub, 7 signed slt, others 0
    function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] c);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a * b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    logic [31:0] aluOut;
    always_comb aluOut = aluModel(bus.alu_src1_o, bus.alu_src2_o, bus.alu_ctrl_o);
    assign bus.alu_result_i = aluOut;
    assign bus.alu_zero_i   = (aluOut == 32'd0);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveReq(input bit isB, input logic v, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [3:0] c);
        if (isB) begin
            bus.reqb_valid_i = v; bus.reqb_src1_i = s1; bus.reqb_src2_i = s2; bus.reqb_ctrl_i = c;
        end else begin
            bus.reqa_valid_i = v; bus.reqa_src1_i = s1; bus.reqa_src2_i = s2; bus.reqa_ctrl_i = c;
        end
    endtask

    task automatic applyStimulus(input bit isB, input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [3:0] c, input logic [31:0] expRes, input logic expZero);
        exp_t e;
        e.isB = isB; e.result = expRes; e.zero = expZero;
        expQ.push_back(e);
        driveReq(isB, 1'b1, s1, s2, c);
        #1;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (bus.busy_o && n < 20) begin
            tick();
            n++;
        end
        checkOutput(name, {31'd0, bus.busy_o}, 32'd0);
    endtask

    task automatic measureLatency(input string name, input bit isB, input int expected);
        int n = 0;
        while (!(isB ? bus.rspb_valid_o : bus.rspa_valid_o) && n < 10) begin
            tick();
            n++;
        end
        checkOutput(name, n, expected);
    endtask

    task automatic doReset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    // Monitor: pop on each new response, then require it to stay stable while held
    logic        prevA, prevB, curB, heldZero, curZero;
    logic [31:0] heldRes, curRes;
    exp_t        got;
    always @(negedge clk) begin
        if (rst) begin
            prevA = 1'b0;
            prevB = 1'b0;
        end else begin
            if (bus.rspa_valid_o && bus.rspb_valid_o) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL both_rsp_valid: got 1, expected 0");
            end else if (bus.rspa_valid_o || bus.rspb_valid_o) begin
                curB    = bus.rspb_valid_o;
                curRes  = curB ? bus.rspb_result_o : bus.rspa_result_o;
                curZero = curB ? bus.rspb_zero_o : bus.rspa_zero_o;
                if ((curB && !prevB) || (!curB && !prevA)) begin
                    if (expQ.size() == 0) begin
                        vecCount++;
                        missCount++;
                        $display("[TB] FAIL unexpected_rsp: got response on %s, expected none",
                                 curB ? "B" : "A");
                    end else begin
                        got = expQ.pop_front();
                        checkOutput("rsp_owner", {31'd0, curB}, {31'd0, got.isB});
                        checkOutput("rsp_result", curRes, got.result);
                        checkOutput("rsp_zero", {31'd0, curZero}, {31'd0, got.zero});
                        heldRes  = curRes;
                        heldZero = curZero;
                    end
                end else begin
                    checkOutput("rsp_held_result", curRes, heldRes);
                    checkOutput("rsp_held_zero", {31'd0, curZero}, {31'd0, heldZero});
                end
            end
            prevA = bus.rspa_valid_o;
            prevB = bus.rspb_valid_o;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        driveReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        driveReq(1, 1'b0, 32'd0, 32'd0, 4'd0);
        bus.rspa_ready_i = 1'b1;
        bus.rspb_ready_i = 1'b1;
        bus.reqa_valid_i = 1'b1;
        #12;
        checkOutput("reset_busy", {31'd0, bus.busy_o}, 32'd0);
        checkOutput("reset_reqa_ready", {31'd0, bus.reqa_ready_o}, 32'd0);
        checkOutput("reset_rspa_valid", {31'd0, bus.rspa_valid_o}, 32'd0);
        checkOutput("reset_rspb_valid", {31'd0, bus.rspb_valid_o}, 32'd0);
        checkOutput("reset_alu_ctrl", {28'd0, bus.alu_ctrl_o}, 32'd0);
        checkOutput("reset_alu_src1", bus.alu_src1_o, 32'd0);
        bus.reqa_valid_i = 1'b0;
        rst = 1'b0;
        tick();

        // Single A add
        applyStimulus(0, 32'd5, 32'd7, 4'd2, 32'd12, 1'b0);
        checkOutput("add_reqa_ready", {31'd0, bus.reqa_ready_o}, 32'd1);
        checkOutput("add_reqb_ready", {31'd0, bus.reqb_ready_o}, 32'd0);
        tick();
        driveReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("add_alu_ctrl", {28'd0, bus.alu_ctrl_o}, 32'd2);
        checkOutput("add_alu_src1", bus.alu_src1_o, 32'd5);
        checkOutput("add_busy", {31'd0, bus.busy_o}, 32'd1);
        measureLatency("add_latency", 0, 1);
        checkOutput("add_rspb_valid", {31'd0, bus.rspb_valid_o}, 32'd0);
        waitIdle("add_done");

        // Tie from reset, then round-robin alternation
        doReset();
        tick();
        driveReq(1, 1'b1, 32'hFFFF_FFFD, 32'd2, 4'd7);
        applyStimulus(0, 32'd9, 32'd9, 4'd6, 32'd0, 1'b1);
        checkOutput("tie_reqa_ready", {31'd0, bus.reqa_ready_o}, 32'd1);
        checkOutput("tie_reqb_ready", {31'd0, bus.reqb_ready_o}, 32'd0);
        tick();
        driveReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("tie_b_blocked", {31'd0, bus.reqb_ready_o}, 32'd0);
        waitIdle("tie_a_done");
        applyStimulus(1, 32'hFFFF_FFFD, 32'd2, 4'd7, 32'd1, 1'b0);
        applyStimulus(0, 32'd5, 32'd3, 4'd1, 32'd7, 1'b0);
        checkOutput("rr_b_wins", {31'd0, bus.reqb_ready_o}, 32'd1);
        checkOutput("rr_a_loses", {31'd0, bus.reqa_ready_o}, 32'd0);
        tick();
        driveReq(1, 1'b0, 32'd0, 32'd0, 4'd0);
        waitIdle("rr_b_done");
        applyStimulus(1, 32'd12, 32'd10, 4'd0, 32'd8, 1'b0);
        checkOutput("rr_a_wins", {31'd0, bus.reqa_ready_o}, 32'd1);
        checkOutput("rr_b_loses", {31'd0, bus.reqb_ready_o}, 32'd0);
        tick();
        driveReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        waitIdle("rr_a_done");
        tick();
        driveReq(1, 1'b0, 32'd0, 32'd0, 4'd0);
        waitIdle("rr_b2_done");

        // Multicycle multiply
        applyStimulus(0, 32'd6, 32'd7, 4'd3, 32'd42, 1'b0);
        tick();
        driveReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("mul_alu_ctrl", {28'd0, bus.alu_ctrl_o}, 32'd3);
        measureLatency("mul_latency", 0, MUL_LAT);
        waitIdle("mul_done");

        // Response backpressure with B waiting
        bus.rspa_ready_i = 1'b0;
        applyStimulus(0, 32'd100, 32'd23, 4'd2, 32'd123, 1'b0);
        tick();
        driveReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        applyStimulus(1, 32'd7, 32'd8, 4'd2, 32'd15, 1'b0);
        measureLatency("bp_latency", 0, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_b_blocked", {31'd0, bus.reqb_ready_o}, 32'd0);
            checkOutput("bp_rspa_held", {31'd0, bus.rspa_valid_o}, 32'd1);
            tick();
        end
        bus.rspa_ready_i = 1'b1;
        tick();
        checkOutput("bp_b_granted", {31'd0, bus.reqb_ready_o}, 32'd1);
        tick();
        driveReq(1, 1'b0, 32'd0, 32'd0, 4'd0);
        waitIdle("bp_done");

        // Async reset mid-EXEC discards the operation
        driveReq(0, 1'b1, 32'd6, 32'd7, 4'd3);
        #1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", {31'd0, bus.busy_o}, 32'd0);
        checkOutput("abort_reqa_ready", {31'd0, bus.reqa_ready_o}, 32'd0);
        checkOutput("abort_alu_ctrl", {28'd0, bus.alu_ctrl_o}, 32'd0);
        checkOutput("abort_alu_src1", bus.alu_src1_o, 32'd0);
        checkOutput("abort_rspa_valid", {31'd0, bus.rspa_valid_o}, 32'd0);
        driveReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        #2;
        rst = 1'b0;
        repeat (6) tick();
        checkOutput("abort_no_rsp", {31'd0, bus.rspa_valid_o}, 32'd0);

        // Post-reset tie goes to A; B then issues an unsupported ctrl code
        applyStimulus(0, 32'd10, 32'd3, 4'd6, 32'd7, 1'b0);
        applyStimulus(1, 32'd1, 32'd1, 4'd4, 32'd0, 1'b1);
        checkOutput("post_tie_reqa_ready", {31'd0, bus.reqa_ready_o}, 32'd1);
        checkOutput("post_tie_reqb_ready", {31'd0, bus.reqb_ready_o}, 32'd0);
        tick();
        driveReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        waitIdle("post_tie_a_done");
        tick();
        driveReq(1, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("unsup_alu_ctrl", {28'd0, bus.alu_ctrl_o}, 32'd4);
        waitIdle("unsup_done");

        repeat (3) tick();
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
